// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 key schedule emitting round keys 0..NR on a valid/ready stream.
// Holds the FIPS-197 S-box used for SubWord and the key-expansion FSM.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);
   // Entry for input x sits in TABLE[(255-x)*8 +: 8], so entry 0 is the leftmost byte.
   localparam logic [2047:0] TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign s = TABLE[{~a, 3'b000} +: 8];
endmodule

module aes_key_expand #(
   parameter int unsigned NR        = 10,
   parameter logic [7:0]  RCON_INIT = 8'h01
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key,
   input  logic         rk_ready,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         rk_valid,
   output logic         busy,
   output logic         done
);
   typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

   localparam logic [3:0] LAST_IDX = 4'(NR);

   state_t       state;
   logic [7:0]   rcon;
   logic [31:0]  rot_word;
   logic [31:0]  sub_word;
   logic [31:0]  t_word;
   logic [31:0]  w0_next, w1_next, w2_next, w3_next;
   logic [127:0] next_key;
   logic         accept;

   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
   endfunction

   assign rot_word = {round_key[23:0], round_key[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_sub
      aes_sbox u_sbox (
         .a (rot_word[8*b +: 8]),
         .s (sub_word[8*b +: 8])
      );
   end

   // Each new word chains off the one just produced, all from the registered key.
   assign t_word   = sub_word ^ {rcon, 24'h0};
   assign w0_next  = round_key[127:96] ^ t_word;
   assign w1_next  = round_key[95:64]  ^ w0_next;
   assign w2_next  = round_key[63:32]  ^ w1_next;
   assign w3_next  = round_key[31:0]   ^ w2_next;
   assign next_key = {w0_next, w1_next, w2_next, w3_next};

   assign accept = rk_valid & rk_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         round_key <= '0;
         round_idx <= '0;
         rk_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rcon      <= RCON_INIT;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  round_key <= key;
                  round_idx <= '0;
                  rcon      <= RCON_INIT;
                  rk_valid  <= 1'b1;
                  busy      <= 1'b1;
                  state     <= EMIT;
               end
            end
            EMIT: begin
               if (accept) begin
                  if (round_idx == LAST_IDX) begin
                     rk_valid <= 1'b0;
                     done     <= 1'b1;
                     state    <= DONE;
                  end else begin
                     round_key <= next_key;
                     round_idx <= round_idx + 4'd1;
                     rcon      <= xtime(rcon);
                  end
               end
            end
            DONE: begin
               // start is deliberately ignored here; the next request is taken from IDLE.
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               rk_valid <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - self-checking bench for aes_key_expand against a word-level key schedule model.

module tb_aes_key_expand;
   localparam int NR = 10;
   localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [127:0] key;
   logic         rk_ready;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         rk_valid;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]   sbox_m [256];
   logic [127:0] exp_rk [NR+1];
   logic [127:0] got    [NR+1];

   aes_key_expand #(.NR(NR), .RCON_INIT(8'h01)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .key       (key),
      .rk_ready  (rk_ready),
      .round_key (round_key),
      .round_idx (round_idx),
      .rk_valid  (rk_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box from first principles: multiplicative inverse in GF(2^8) then the affine map.
   task automatic build_sbox();
      for (int v = 0; v < 256; v++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (v != 0 && gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic model(input logic [127:0] k);
      logic [31:0] w [4*(NR+1)];
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 4*(NR+1); i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
            tmp ^= {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r <= NR; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Runs one expansion starting at a negedge in IDLE; ends at the negedge of the first IDLE cycle after DONE.
   task automatic expand(input logic [127:0] k, input int stall_idx, input int stall_len,
                         input int poke_idx, input bit poke_done, input string tag);
      int idx = 0;
      int stalled = 0;
      int cycles = 0;
      int shown;
      model(k);
      key = k; start = 1'b1; rk_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      key = ~k;
      while (idx <= NR && cycles < 64) begin
         shown = idx;
         check({tag, " valid"}, 128'(rk_valid), 128'd1);
         check({tag, " idx"}, 128'(round_idx), 128'(idx));
         check({tag, " key"}, round_key, exp_rk[idx]);
         check({tag, " busy"}, 128'(busy), 128'd1);
         check({tag, " done_low"}, 128'(done), 128'd0);
         got[idx] = round_key;
         if (idx == stall_idx && stalled < stall_len) begin
            rk_ready = 1'b0;
            stalled++;
         end else begin
            rk_ready = 1'b1;
            idx++;
         end
         start = (shown == poke_idx);
         cycles++;
         @(negedge clk);
      end
      check({tag, " cycles"}, 128'(cycles), 128'(NR + 1 + stall_len));
      start = poke_done;
      rk_ready = 1'($urandom);
      check({tag, " done"}, 128'(done), 128'd1);
      check({tag, " done_busy"}, 128'(busy), 128'd1);
      check({tag, " done_valid"}, 128'(rk_valid), 128'd0);
      @(negedge clk);
      start = 1'b0;
      check({tag, " idle_done"}, 128'(done), 128'd0);
      check({tag, " idle_busy"}, 128'(busy), 128'd0);
      check({tag, " idle_valid"}, 128'(rk_valid), 128'd0);
   endtask

   initial begin
      logic [127:0] rkey;
      rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key = '0;
      build_sbox();
      #12;
      check("rst key", round_key, 128'd0);
      check("rst idx", 128'(round_idx), 128'd0);
      check("rst valid", 128'(rk_valid), 128'd0);
      check("rst busy", 128'(busy), 128'd0);
      check("rst done", 128'(done), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      expand(KEY_A1, -1, 0, -1, 1'b0, "a1");
      check("a1 k0", got[0], KEY_A1);
      check("a1 k1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
      check("a1 k10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      expand(128'd0, -1, 0, -1, 1'b0, "zero");
      check("zero k1", got[1], 128'h62636363626363636263636362636363);

      expand(KEY_A1, 4, 3, -1, 1'b0, "stall");
      check("stall k10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      expand(KEY_A1, -1, 0, 6, 1'b1, "poke");
      check("poke k10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rkey = {$urandom, $urandom, $urandom, $urandom};
      expand(rkey, -1, 0, -1, 1'b0, "b2b");

      key = KEY_A1; start = 1'b1; rk_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      check("pre_rst idx", 128'(round_idx), 128'd7);
      rst_n = 1'b0;
      #1;
      check("mid_rst key", round_key, 128'd0);
      check("mid_rst idx", 128'(round_idx), 128'd0);
      check("mid_rst valid", 128'(rk_valid), 128'd0);
      check("mid_rst busy", 128'(busy), 128'd0);
      check("mid_rst done", 128'(done), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst done", 128'(done), 128'd0);
      rkey = {$urandom, $urandom, $urandom, $urandom};
      expand(rkey, -1, 0, -1, 1'b0, "after_rst");

      for (int n = 0; n < 6; n++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom};
         expand(rkey, int'($urandom_range(0, NR)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, NR)), 1'($urandom), "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
